merge_arbiter: RTL and testbench
================================

Name: merge_arbiter

Overview:
- Shares one merge_network (sum of NUM_INPUTS elements, BIT_WIDTH each) among NUM_REQ requesters, such as PE rows or partial-sum channels.
- Each requester presents a full input vector with a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle. The merged sum and the requester ID are registered into a single-entry output stage with backpressure.
- Sits between PE partial-sum outputs and the accumulation/writeback path.

Parameters:
- NUM_INPUTS, 18, elements per merge vector.
- BIT_WIDTH, 8, bit width of each element and of the sum.
- NUM_REQ, 4, number of requesters (>=2).
- COUNT_WIDTH, 16, width of the completed-merge counter.
- ID_WIDTH (localparam), max(1, clog2(NUM_REQ)), requester ID width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester valid.
- req_data  input  NUM_REQ*NUM_INPUTS*BIT_WIDTH  per-requester vector; requester r occupies slice [r*NUM_INPUTS*BIT_WIDTH +: NUM_INPUTS*BIT_WIDTH].
- req_ready  output  NUM_REQ  one-hot grant/accept (combinational).
- out_valid  output  1  merged result valid.
- out_ready  input  1  downstream accept.
- out_data  output  BIT_WIDTH  merged sum.
- out_id  output  ID_WIDTH  index of the requester that produced out_data.
- merge_count  output  COUNT_WIDTH  number of accepted requests since reset.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_id=0, merge_count=0, rr_ptr=0 (requester 0 has highest priority).
- Stage enable: advance = !out_valid || out_ready.
- Arbitration (combinational):
  - Search req_valid starting at rr_ptr, ascending with wrap from NUM_REQ-1 to 0; the first set bit wins.
  - req_ready[winner] = advance. All other req_ready bits = 0.
  - If no req_valid bit is set, req_ready = 0.
- Transfer occurs when req_valid[w] && req_ready[w]. On a transfer at edge N:
  - out_data <= sum of the winner's NUM_INPUTS elements, truncated modulo 2^BIT_WIDTH (unsigned wrap, identical to merge_network). Computed by an internal merge_network instance fed by a NUM_REQ:1 mux of req_data.
  - out_id <= w.
  - out_valid <= 1.
  - rr_ptr <= (w+1) mod NUM_REQ.
  - merge_count <= merge_count+1, wrapping at 2^COUNT_WIDTH.
- Latency: 1 cycle from handshake to out_valid.
- Throughput: 1 result per cycle while out_ready=1.
- advance=1 with no transfer: out_valid <= 0 (out_ready drained it, or it was already empty). out_data and out_id hold their last values. rr_ptr is unchanged.
- Backpressure: out_valid=1 && out_ready=0 means all req_ready=0, and out_data, out_id, out_valid, rr_ptr and merge_count are all stable.
- Output handshake and new grant in the same cycle (out_valid=1 && out_ready=1 && a request pending): the old result is consumed and the new result is loaded at the same edge, with no bubble.
- Requester rules:
  - A requester holds valid and data stable until it sees ready.
  - The arbiter does not retain a grant across cycles; a newly arriving higher-priority valid may win in a later cycle.
- Only one grant per cycle. No requester starves: the maximum wait is NUM_REQ-1 grants while out_ready remains asserted.
- Reset mid-operation: an in-flight output is dropped (out_valid=0 on the cycle after the rst edge), and the pointer and counter clear. Requests are not accepted while rst=1 (req_ready forced to 0).

Test Plan:
All scenarios use NUM_INPUTS=4, BIT_WIDTH=8, NUM_REQ=3.
- Single request: req_valid=3'b001, req0 data {1,2,3,4}, out_ready=1 -> req_ready=3'b001 that cycle; next cycle out_valid=1, out_data=10, out_id=0, merge_count=1.
- Overflow: req2 data {200,100,0,0} -> out_data=44 (300 mod 256), out_id=2.
- Full contention: req_valid=3'b111 held, out_ready=1 -> grant order 0,1,2,0,1,2; out_id follows the same sequence one per cycle; merge_count=6 after 6 cycles.
- Pointer fairness: grant to requester 1, then req_valid=3'b101 -> requester 2 is granted before requester 0.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with req_valid=3'b111 -> req_ready=0 and outputs stable; the cycle out_ready rises, the next round-robin grant loads with no bubble.
- Reset mid-stream: rst=1 for one cycle while out_valid=1 -> out_valid=0, merge_count=0; the next grant with req_valid=3'b111 goes to requester 0.

Source files
------------

// File: rtl/merge_arbiter.sv
// merge_arbiter: round-robin sharing of one merge_network among NUM_REQ
// requesters, with a single registered output stage and backpressure.

module merge_network #(
  parameter int NUM_INPUTS = 18,
  parameter int BIT_WIDTH  = 8
) (
  input  logic [NUM_INPUTS*BIT_WIDTH-1:0] data,
  output logic [BIT_WIDTH-1:0]            sum
);

  // Unsigned sum of all elements, wrapping modulo 2^BIT_WIDTH
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      sum = sum + data[i*BIT_WIDTH +: BIT_WIDTH];
  end

endmodule

module merge_arbiter #(
  parameter int NUM_INPUTS  = 18,
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_REQ     = 4,
  parameter int COUNT_WIDTH = 16,
  localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ*NUM_INPUTS*BIT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [BIT_WIDTH-1:0]                   out_data,
  output logic [ID_WIDTH-1:0]                    out_id,
  output logic [COUNT_WIDTH-1:0]                 merge_count
);

  localparam int VW = NUM_INPUTS * BIT_WIDTH;

  logic [ID_WIDTH-1:0]  rr_ptr;
  logic [ID_WIDTH-1:0]  winner;
  logic [ID_WIDTH-1:0]  next_ptr;
  logic                 found;
  logic                 advance;
  logic                 transfer;
  logic [VW-1:0]        sel_vec;
  logic [BIT_WIDTH-1:0] sel_sum;

  assign advance  = !out_valid || out_ready;
  assign transfer = found && advance && !rst;
  assign next_ptr = (winner == ID_WIDTH'(NUM_REQ-1)) ? '0 : winner + 1'b1;

  // Round-robin search starting at rr_ptr, wrapping past NUM_REQ-1
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_WIDTH'(idx);
      end
    end
  end

  // One-hot accept and data mux for the winning requester
  always_comb begin
    req_ready = '0;
    sel_vec   = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (winner == ID_WIDTH'(r)) begin
        req_ready[r] = transfer;
        sel_vec      = req_data[r*VW +: VW];
      end
    end
  end

  merge_network #(
    .NUM_INPUTS (NUM_INPUTS),
    .BIT_WIDTH  (BIT_WIDTH)
  ) u_merge (
    .data (sel_vec),
    .sum  (sel_sum)
  );

  // Output stage: load on transfer, drain when accepted, hold on stall
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_id      <= '0;
      merge_count <= '0;
      rr_ptr      <= '0;
    end else if (advance) begin
      if (transfer) begin
        out_valid   <= 1'b1;
        out_data    <= sel_sum;
        out_id      <= winner;
        rr_ptr      <= next_ptr;
        merge_count <= merge_count + 1'b1;
      end else begin
        out_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_merge_arbiter.sv
// tb_merge_arbiter: directed checks of arbitration, sum, backpressure, reset
// for NUM_INPUTS=4, BIT_WIDTH=8, NUM_REQ=3.

module tb_merge_arbiter;

  localparam int NI = 4;
  localparam int BW = 8;
  localparam int NR = 3;
  localparam int CW = 16;
  localparam int IW = 2;

  logic                clk;
  logic                rst;
  logic [NR-1:0]       req_valid;
  logic [NR*NI*BW-1:0] req_data;
  logic [NR-1:0]       req_ready;
  logic                out_valid;
  logic                out_ready;
  logic [BW-1:0]       out_data;
  logic [IW-1:0]       out_id;
  logic [CW-1:0]       merge_count;

  int tests = 0;
  int fails = 0;

  merge_arbiter #(
    .NUM_INPUTS  (NI),
    .BIT_WIDTH   (BW),
    .NUM_REQ     (NR),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_id      (out_id),
    .merge_count (merge_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input int a, input int b,
                         input int c, input int d);
    req_data[r*NI*BW + 0*BW +: BW] = BW'(a);
    req_data[r*NI*BW + 1*BW +: BW] = BW'(b);
    req_data[r*NI*BW + 2*BW +: BW] = BW'(c);
    req_data[r*NI*BW + 3*BW +: BW] = BW'(d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    req_valid = 3'b111;
    #1;
    tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL reset_ready got %b exp 000", req_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    tests++; if (out_data !== 8'd0) begin fails++; $display("FAIL reset_data got %0d exp 0", out_data); end
    tests++; if (out_id !== 2'd0) begin fails++; $display("FAIL reset_id got %0d exp 0", out_id); end
    tests++; if (merge_count !== 16'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", merge_count); end
    req_valid = 3'b000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_req(0, 1, 2, 3, 4);
    req_valid = 3'b001;
    out_ready = 1'b1;
    #1;
    tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL single_ready got %b exp 001", req_ready); end
    step();
    req_valid = 3'b000;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", out_valid); end
    tests++; if (out_data !== 8'd10) begin fails++; $display("FAIL single_data got %0d exp 10", out_data); end
    tests++; if (out_id !== 2'd0) begin fails++; $display("FAIL single_id got %0d exp 0", out_id); end
    tests++; if (merge_count !== 16'd1) begin fails++; $display("FAIL single_count got %0d exp 1", merge_count); end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_valid got %b exp 0", out_valid); end
    tests++; if (out_data !== 8'd10) begin fails++; $display("FAIL drain_hold got %0d exp 10", out_data); end
  endtask

  task automatic test_overflow();
    set_req(2, 200, 100, 0, 0);
    req_valid = 3'b100;
    #1;
    tests++; if (req_ready !== 3'b100) begin fails++; $display("FAIL ovf_ready got %b exp 100", req_ready); end
    step();
    req_valid = 3'b000;
    tests++; if (out_data !== 8'd44) begin fails++; $display("FAIL ovf_data got %0d exp 44", out_data); end
    tests++; if (out_id !== 2'd2) begin fails++; $display("FAIL ovf_id got %0d exp 2", out_id); end
    tests++; if (merge_count !== 16'd2) begin fails++; $display("FAIL ovf_count got %0d exp 2", merge_count); end
    step();
  endtask

  task automatic test_contention();
    int w;
    set_req(0, 1, 1, 1, 1);
    set_req(1, 2, 2, 2, 2);
    set_req(2, 3, 3, 3, 3);
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      w = i % 3;
      #1;
      tests++; if (req_ready !== NR'(1 << w)) begin fails++; $display("FAIL cont_ready[%0d] got %b exp %b", i, req_ready, NR'(1 << w)); end
      step();
      tests++; if (out_id !== IW'(w)) begin fails++; $display("FAIL cont_id[%0d] got %0d exp %0d", i, out_id, w); end
      tests++; if (out_data !== BW'(4 * (w + 1))) begin fails++; $display("FAIL cont_data[%0d] got %0d exp %0d", i, out_data, 4 * (w + 1)); end
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL cont_valid[%0d] got %b exp 1", i, out_valid); end
    end
    tests++; if (merge_count !== 16'd8) begin fails++; $display("FAIL cont_count got %0d exp 8", merge_count); end
    req_valid = 3'b000;
    step();
  endtask

  task automatic test_fairness();
    req_valid = 3'b010;
    step();
    tests++; if (out_id !== 2'd1) begin fails++; $display("FAIL fair_first got %0d exp 1", out_id); end
    req_valid = 3'b101;
    #1;
    tests++; if (req_ready !== 3'b100) begin fails++; $display("FAIL fair_ready2 got %b exp 100", req_ready); end
    step();
    tests++; if (out_id !== 2'd2) begin fails++; $display("FAIL fair_id2 got %0d exp 2", out_id); end
    #1;
    tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL fair_ready0 got %b exp 001", req_ready); end
    step();
    tests++; if (out_id !== 2'd0) begin fails++; $display("FAIL fair_id0 got %0d exp 0", out_id); end
    tests++; if (merge_count !== 16'd11) begin fails++; $display("FAIL fair_count got %0d exp 11", merge_count); end
    req_valid = 3'b000;
    step();
  endtask

  task automatic test_backpressure();
    req_valid = 3'b111;
    out_ready = 1'b1;
    step();
    tests++; if (out_id !== 2'd1) begin fails++; $display("FAIL bp_load_id got %0d exp 1", out_id); end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL bp_ready[%0d] got %b exp 000", i, req_ready); end
      step();
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got %b exp 1", i, out_valid); end
      tests++; if (out_id !== 2'd1) begin fails++; $display("FAIL bp_id[%0d] got %0d exp 1", i, out_id); end
      tests++; if (out_data !== 8'd8) begin fails++; $display("FAIL bp_data[%0d] got %0d exp 8", i, out_data); end
      tests++; if (merge_count !== 16'd12) begin fails++; $display("FAIL bp_count[%0d] got %0d exp 12", i, merge_count); end
    end
    out_ready = 1'b1;
    #1;
    tests++; if (req_ready !== 3'b100) begin fails++; $display("FAIL bp_release_ready got %b exp 100", req_ready); end
    step();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_nobubble got %b exp 1", out_valid); end
    tests++; if (out_id !== 2'd2) begin fails++; $display("FAIL bp_next_id got %0d exp 2", out_id); end
    tests++; if (out_data !== 8'd12) begin fails++; $display("FAIL bp_next_data got %0d exp 12", out_data); end
    tests++; if (merge_count !== 16'd13) begin fails++; $display("FAIL bp_next_count got %0d exp 13", merge_count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL rmid_ready got %b exp 000", req_ready); end
    step();
    rst = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
    tests++; if (merge_count !== 16'd0) begin fails++; $display("FAIL rmid_count got %0d exp 0", merge_count); end
    out_ready = 1'b1;
    req_valid = 3'b111;
    #1;
    tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL rmid_grant got %b exp 001", req_ready); end
    step();
    tests++; if (out_id !== 2'd0) begin fails++; $display("FAIL rmid_id got %0d exp 0", out_id); end
    tests++; if (merge_count !== 16'd1) begin fails++; $display("FAIL rmid_count1 got %0d exp 1", merge_count); end
    req_valid = 3'b000;
    step();
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_contention();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
